// File: rtl/scan_arbiter.sv
// Round-robin arbiter sharing one scan_controller between several requesters.
// Each grant drives the chain for whole scan rounds, then returns the captured outputs.
module scan_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_DESIGNS    = 4,
    parameter int HOLD_ROUNDS    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [9*NUM_REQ-1:0] req_sel,
    input  logic [8*NUM_REQ-1:0] req_inputs,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_data,
    output logic [1:0]           resp_status,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [8:0]           scan_active_select,
    output logic [7:0]           scan_inputs,
    input  logic [7:0]           scan_outputs,
    input  logic                 scan_ready
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW  = $clog2(HOLD_ROUNDS + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]  HR      = RW'(HOLD_ROUNDS);
    localparam logic [9:0]     ND      = 10'(NUM_DESIGNS);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t         state;
    logic           ready_q;
    logic [2:0]     rr_ptr;
    logic [RW-1:0]  rounds;
    logic [WDW-1:0] wdog;

    logic           rise;
    logic           found;
    logic [2:0]     winner;
    logic [2:0]     next_ptr;
    logic [8:0]     win_sel;
    logic [7:0]     win_in;
    logic           accept;
    logic           sel_ok;
    logic [RW-1:0]  rounds_next;
    int             idx;

    assign rise = scan_ready & ~ready_q;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    assign win_sel     = req_sel[9*int'(winner) +: 9];
    assign win_in      = req_inputs[8*int'(winner) +: 8];
    assign sel_ok      = {1'b0, win_sel} < ND;
    assign next_ptr    = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
    assign accept      = ~reset & (state == IDLE) & rise & found;
    assign req_ready   = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rounds_next = rounds + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            ready_q            <= 1'b0;
            rr_ptr             <= 3'd0;
            rounds             <= '0;
            wdog               <= '0;
            busy               <= 1'b0;
            grant_id           <= 3'd0;
            resp_valid         <= '0;
            resp_data          <= 8'd0;
            resp_status        <= 2'b00;
            scan_active_select <= 9'd0;
            scan_inputs        <= 8'd0;
        end else begin
            ready_q    <= scan_ready;
            resp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr   <= next_ptr;
                        grant_id <= winner;
                        if (sel_ok) begin
                            scan_active_select <= win_sel;
                            scan_inputs        <= win_in;
                            busy               <= 1'b1;
                            rounds             <= '0;
                            wdog               <= '0;
                            state              <= HOLD;
                        end else begin
                            resp_data   <= 8'd0;
                            resp_status <= 2'b10;
                            resp_valid  <= NUM_REQ'(1) << winner;
                            state       <= RESP;
                        end
                    end
                end
                HOLD: begin
                    // A rise beats a coincident watchdog expiry.
                    if (rise) begin
                        wdog   <= '0;
                        rounds <= rounds_next;
                        if (rounds_next == HR) begin
                            resp_data   <= scan_outputs;
                            resp_status <= 2'b00;
                            resp_valid  <= NUM_REQ'(1) << grant_id;
                            state       <= RESP;
                        end
                    end else if (wdog == WD_LAST) begin
                        resp_data   <= 8'd0;
                        resp_status <= 2'b01;
                        resp_valid  <= NUM_REQ'(1) << grant_id;
                        state       <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
